// File: rtl/mem_req_collector.sv
// Gathers one load/store per core behind a barrier, holds the batch on the
// controller lines for a fixed window, then returns read data and acks.
module mem_req_collector #(
    parameter int ISSUE_CYCLES = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  core_active,
    input  logic [3:0]  core_req,
    input  logic [3:0]  core_store,
    input  logic [63:0] core_addr,
    input  logic [63:0] core_wdata,
    output logic [3:0]  core_ack,
    output logic [63:0] core_rdata,
    output logic        busy,
    output logic [3:0]  mc_op,
    output logic [3:0]  mc_wr,
    output logic [3:0]  mc_mr,
    output logic [63:0] mc_addr,
    output logic [63:0] mc_data,
    input  logic [63:0] mc_dout
);

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, RESP} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [3:0] IssueLast   = 4'(ISSUE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  slotValid_q, slotValid_d;
    logic [3:0]  slotStore_q, slotStore_d;
    logic [63:0] slotAddr_q, slotAddr_d;
    logic [63:0] slotWdata_q, slotWdata_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  issueCnt_q, issueCnt_d;
    logic [3:0]  mcOp_q, mcOp_d;
    logic [3:0]  mcWr_q, mcWr_d;
    logic [3:0]  mcMr_q, mcMr_d;
    logic [63:0] mcAddr_q, mcAddr_d;
    logic [63:0] mcData_q, mcData_d;
    logic [3:0]  ack_q, ack_d;
    logic [63:0] rdata_q, rdata_d;

    logic [3:0]  capture;
    logic [3:0]  postValid;
    logic        barrier;
    logic        loadIssue;

    // Barrier is judged on post-capture slots; inactive cores never block it.
    always_comb begin
        capture     = '0;
        if (state_q == IDLE || state_q == COLLECT) begin
            capture = core_req & core_active & ~slotValid_q;
        end
        postValid   = slotValid_q | capture;
        barrier     = &(postValid | ~core_active);

        state_d     = state_q;
        slotValid_d = postValid;
        slotStore_d = slotStore_q;
        slotAddr_d  = slotAddr_q;
        slotWdata_d = slotWdata_q;
        timer_d     = timer_q;
        issueCnt_d  = issueCnt_q;
        mcOp_d      = mcOp_q;
        mcWr_d      = mcWr_q;
        mcMr_d      = mcMr_q;
        mcAddr_d    = mcAddr_q;
        mcData_d    = mcData_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        loadIssue   = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (capture[i]) begin
                slotStore_d[i]         = core_store[i];
                slotAddr_d[16*i +: 16]  = core_addr[16*i +: 16];
                slotWdata_d[16*i +: 16] = core_wdata[16*i +: 16];
            end
        end

        case (state_q)
            IDLE: begin
                if (|capture) begin
                    timer_d = '0;
                    if (barrier) begin
                        state_d   = ISSUE;
                        loadIssue = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                timer_d = timer_q + 8'd1;
                if (barrier || timer_q == TimeoutLast) begin
                    state_d   = ISSUE;
                    loadIssue = 1'b1;
                end
            end
            ISSUE: begin
                if (issueCnt_q == '0) begin
                    state_d  = RESP;
                    ack_d    = slotValid_q;
                    mcOp_d   = '0;
                    mcWr_d   = '0;
                    mcMr_d   = '0;
                    mcAddr_d = '0;
                    mcData_d = '0;
                    for (int i = 0; i < 4; i++) begin
                        if (slotValid_q[i] && !slotStore_q[i]) begin
                            rdata_d[16*i +: 16] = mc_dout[16*i +: 16];
                        end
                    end
                end else begin
                    issueCnt_d = issueCnt_q - 4'd1;
                end
            end
            RESP: begin
                slotValid_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Controller lines are latched once, on entry to ISSUE.
        if (loadIssue) begin
            issueCnt_d = IssueLast;
            mcOp_d     = postValid;
            mcWr_d     = postValid & slotStore_d;
            mcMr_d     = postValid & ~slotStore_d;
            for (int i = 0; i < 4; i++) begin
                mcAddr_d[16*i +: 16] = postValid[i] ? slotAddr_d[16*i +: 16] : 16'h0;
                mcData_d[16*i +: 16] = (postValid[i] && slotStore_d[i]) ?
                                       slotWdata_d[16*i +: 16] : 16'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slotValid_q <= '0;
            slotStore_q <= '0;
            slotAddr_q  <= '0;
            slotWdata_q <= '0;
            timer_q     <= '0;
            issueCnt_q  <= '0;
            mcOp_q      <= '0;
            mcWr_q      <= '0;
            mcMr_q      <= '0;
            mcAddr_q    <= '0;
            mcData_q    <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            slotValid_q <= slotValid_d;
            slotStore_q <= slotStore_d;
            slotAddr_q  <= slotAddr_d;
            slotWdata_q <= slotWdata_d;
            timer_q     <= timer_d;
            issueCnt_q  <= issueCnt_d;
            mcOp_q      <= mcOp_d;
            mcWr_q      <= mcWr_d;
            mcMr_q      <= mcMr_d;
            mcAddr_q    <= mcAddr_d;
            mcData_q    <= mcData_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign core_ack   = ack_q;
    assign core_rdata = rdata_q;
    assign mc_op      = mcOp_q;
    assign mc_wr      = mcWr_q;
    assign mc_mr      = mcMr_q;
    assign mc_addr    = mcAddr_q;
    assign mc_data    = mcData_q;

endmodule
